// File: rtl/fanin_collector.sv
`default_nettype none
// ============================================================================
// Module   : fanin_collector
// Purpose  : Far-end sink of a buffered fanout tree. Collects one token per
//            branch, then emits the merged token with a mismatch flag (the
//            branches disagreed) and a timeout flag (not every branch arrived).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            br_valid/ready  - per-branch handshake, one token per round
//            br_data         - branch i at [i*DATA_W +: DATA_W]
//            out_valid/ready - merged-result handshake
//            out_data        - token of the lowest-index arrived branch
//            out_mask        - branches that arrived this round
//            out_mismatch    - an arrived token differs from out_data
//            out_timeout     - round closed by timeout rather than completion
// Revision : 1.0 - initial release
// ============================================================================
module fanin_collector #(
  parameter int NUM_BRANCH = 4,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BRANCH-1:0]        br_valid,
  input  logic [NUM_BRANCH*DATA_W-1:0] br_data,
  output logic [NUM_BRANCH-1:0]        br_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [NUM_BRANCH-1:0]        out_mask,
  output logic                         out_mismatch,
  output logic                         out_timeout
);

  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_BRANCH-1:0] r_arrived;
  logic [NUM_BRANCH-1:0] w_accept;
  logic [NUM_BRANCH-1:0] w_arrived_nxt;
  logic [DATA_W-1:0]     r_cap     [NUM_BRANCH];
  logic [DATA_W-1:0]     w_cap_nxt [NUM_BRANCH];
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_ready_en;
  logic                  w_load_out;
  logic                  w_timeout_nxt;
  logic                  w_release;
  logic [DATA_W-1:0]     w_merge_data;
  logic                  w_merge_mismatch;
  logic [DATA_W-1:0]     r_out_data;
  logic [NUM_BRANCH-1:0] r_out_mask;
  logic                  r_out_mismatch;
  logic                  r_out_timeout;

  // A branch that already delivered is stalled until the round is handed off.
  assign w_ready_en    = (r_state != S_EMIT) & ~rst;
  assign br_ready      = {NUM_BRANCH{w_ready_en}} & ~r_arrived;
  assign w_accept      = br_valid & br_ready;
  assign w_arrived_nxt = r_arrived | w_accept;
  assign w_release     = (r_state == S_EMIT) & out_ready;

  // Captures as they will look after this edge, so the merged result can be
  // registered on the same edge that completes the round.
  always_comb begin
    for (int i = 0; i < NUM_BRANCH; i++) begin
      w_cap_nxt[i] = w_accept[i] ? br_data[i*DATA_W +: DATA_W] : r_cap[i];
    end
  end

  always_comb begin
    w_merge_data = '0;
    for (int i = NUM_BRANCH - 1; i >= 0; i--) begin
      if (w_arrived_nxt[i]) begin
        w_merge_data = w_cap_nxt[i];
      end
    end
    w_merge_mismatch = 1'b0;
    for (int i = 0; i < NUM_BRANCH; i++) begin
      if (w_arrived_nxt[i] && (w_cap_nxt[i] != w_merge_data)) begin
        w_merge_mismatch = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_load_out    = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_accept) begin
          w_cnt_nxt = '0;
          if (&w_arrived_nxt) begin
            w_state_nxt = S_EMIT;
            w_load_out  = 1'b1;
          end else begin
            w_state_nxt = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        // Saturating; the forced exit at C_CNT_MAX means it never wraps.
        w_cnt_nxt = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        // Completion is tested first so it wins over a coincident timeout.
        if (&w_arrived_nxt) begin
          w_state_nxt = S_EMIT;
          w_load_out  = 1'b1;
        end else if (r_cnt == C_CNT_MAX) begin
          w_state_nxt   = S_EMIT;
          w_load_out    = 1'b1;
          w_timeout_nxt = 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_arrived      <= '0;
      r_out_data     <= '0;
      r_out_mask     <= '0;
      r_out_mismatch <= 1'b0;
      r_out_timeout  <= 1'b0;
      for (int i = 0; i < NUM_BRANCH; i++) begin
        r_cap[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_arrived <= w_release ? '0 : w_arrived_nxt;
      for (int i = 0; i < NUM_BRANCH; i++) begin
        r_cap[i] <= w_cap_nxt[i];
      end
      if (w_load_out) begin
        r_out_data     <= w_merge_data;
        r_out_mask     <= w_arrived_nxt;
        r_out_mismatch <= w_merge_mismatch;
        r_out_timeout  <= w_timeout_nxt;
      end else if (w_release) begin
        r_out_data     <= '0;
        r_out_mask     <= '0;
        r_out_mismatch <= 1'b0;
        r_out_timeout  <= 1'b0;
      end
    end
  end

  assign out_valid    = (r_state == S_EMIT);
  assign out_data     = r_out_data;
  assign out_mask     = r_out_mask;
  assign out_mismatch = r_out_mismatch;
  assign out_timeout  = r_out_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fanin_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fanin_collector
// Purpose  : Self-checking bench for fanin_collector. Each round is described
//            as a per-branch arrival time and token; the expected closing
//            cycle, mask, merged token and flags are derived from those with
//            plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fanin_collector;
  localparam int NB = 4;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] br_valid;
  logic [NB*DW-1:0] br_data;
  logic [NB-1:0] br_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_mask;
  logic          out_mismatch;
  logic          out_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Round description: arrival cycle per branch (-1 = never) and its token.
  int            t_off [NB];
  logic [DW-1:0] t_dat [NB];

  always #5 clk = ~clk;

  fanin_collector #(.NUM_BRANCH(NB), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_data(br_data), .br_ready(br_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_mismatch(out_mismatch), .out_timeout(out_timeout)
  );

  // Drives one round, checks per-cycle readiness and the emitted result,
  // holds out_ready low for hold_cycles, then hands off.
  task automatic run_round(input string name, input bit stall_reassert, input int hold_cycles);
    int first, last, close, lo;
    bit all_in;
    logic [NB-1:0] exp_mask, exp_rdy;
    logic [DW-1:0] exp_data;
    bit exp_mis, exp_to;
    first = 1000;
    for (int i = 0; i < NB; i++) if (t_off[i] >= 0 && t_off[i] < first) first = t_off[i];
    for (int i = 0; i < NB; i++) if (t_off[i] >= 0) t_off[i] = t_off[i] - first;
    // Deadline: one edge opens the round, TO+1 further edges in collection.
    all_in = 1'b1;
    last   = 0;
    for (int i = 0; i < NB; i++) begin
      if (t_off[i] < 0 || t_off[i] > TO + 1) all_in = 1'b0;
      else if (t_off[i] > last) last = t_off[i];
    end
    close  = all_in ? last : TO + 1;
    exp_to = !all_in;
    exp_mask = '0;
    for (int i = 0; i < NB; i++) exp_mask[i] = (t_off[i] >= 0 && t_off[i] <= close);
    lo = -1;
    for (int i = NB - 1; i >= 0; i--) if (exp_mask[i]) lo = i;
    exp_data = t_dat[lo];
    exp_mis  = 1'b0;
    for (int i = 0; i < NB; i++) if (exp_mask[i] && t_dat[i] != exp_data) exp_mis = 1'b1;

    out_ready = 1'b0;
    for (int k = 0; k <= close; k++) begin
      br_valid = '0;
      for (int i = 0; i < NB; i++) begin
        if (t_off[i] == k) begin
          br_valid[i] = 1'b1;
          br_data[i*DW +: DW] = t_dat[i];
        end else if (stall_reassert && t_off[i] >= 0 && t_off[i] < k) begin
          br_valid[i] = 1'b1;
          br_data[i*DW +: DW] = 8'hFF;
        end
      end
      @(posedge clk); #1;
      exp_rdy = '0;
      if (k < close)
        for (int i = 0; i < NB; i++) exp_rdy[i] = !(t_off[i] >= 0 && t_off[i] <= k);
      n_checks++;
      if (br_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s br_ready cycle %0d: got %b expected %b", name, k, br_ready, exp_rdy);
      end
      n_checks++;
      if (out_valid !== (k == close)) begin
        n_fail++;
        $display("FAIL %s out_valid cycle %0d: got %b expected %b", name, k, out_valid, (k == close));
      end
    end
    br_valid = '0;

    for (int h = 0; h <= hold_cycles; h++) begin
      n_checks++;
      if ({out_valid, out_data, out_mask, out_mismatch, out_timeout} !==
          {1'b1, exp_data, exp_mask, exp_mis, exp_to}) begin
        n_fail++;
        $display("FAIL %s result hold %0d: got v=%b d=%h m=%b mis=%b to=%b expected v=1 d=%h m=%b mis=%b to=%b",
                 name, h, out_valid, out_data, out_mask, out_mismatch, out_timeout,
                 exp_data, exp_mask, exp_mis, exp_to);
      end
      n_checks++;
      if (br_ready !== '0) begin
        n_fail++;
        $display("FAIL %s br_ready in emit: got %b expected 0000", name, br_ready);
      end
      if (h < hold_cycles) begin
        // Tokens offered while emitting must not be taken.
        br_valid = '1;
        br_data  = {$urandom, $urandom};
        @(posedge clk); #1;
      end
    end
    br_valid  = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_mask !== '0) begin
      n_fail++;
      $display("FAIL %s handoff: got v=%b m=%b expected v=0 m=0000", name, out_valid, out_mask);
    end
    n_checks++;
    if (br_ready !== 4'b1111) begin
      n_fail++;
      $display("FAIL %s ready after handoff: got %b expected 1111", name, br_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; br_valid = '0; br_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_data, out_mask, out_mismatch, out_timeout, br_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got v=%b d=%h m=%b mis=%b to=%b rdy=%b expected all 0",
               out_valid, out_data, out_mask, out_mismatch, out_timeout, br_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (br_ready !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset release br_ready: got %b expected 1111", br_ready);
    end
  endtask

  task automatic test_all_at_once();
    for (int i = 0; i < NB; i++) begin t_off[i] = 0; t_dat[i] = 8'h5A; end
    run_round("all_at_once", 1'b0, 0);
  endtask

  task automatic test_staggered();
    t_off[2] = 0; t_off[0] = 1; t_off[3] = 2; t_off[1] = 3;
    for (int i = 0; i < NB; i++) t_dat[i] = 8'h33;
    run_round("staggered_stall", 1'b1, 0);
  endtask

  task automatic test_mismatch();
    t_dat[0] = 8'h10; t_dat[1] = 8'h10; t_dat[2] = 8'h11; t_dat[3] = 8'h10;
    for (int i = 0; i < NB; i++) t_off[i] = 0;
    run_round("mismatch", 1'b0, 0);
  endtask

  task automatic test_timeout();
    t_off[0] = -1; t_off[1] = 0; t_off[2] = -1; t_off[3] = 0;
    for (int i = 0; i < NB; i++) t_dat[i] = 8'h77;
    run_round("timeout", 1'b0, 0);
  endtask

  task automatic test_completion_wins();
    t_off[0] = 0; t_off[1] = 4; t_off[2] = 9; t_off[3] = TO + 1;
    for (int i = 0; i < NB; i++) t_dat[i] = 8'hC3;
    run_round("completion_wins", 1'b0, 0);
  endtask

  task automatic test_backpressure();
    t_off[0] = 0; t_off[1] = 1; t_off[2] = 1; t_off[3] = 2;
    t_dat[0] = 8'h81; t_dat[1] = 8'h81; t_dat[2] = 8'h81; t_dat[3] = 8'h18;
    run_round("backpressure", 1'b0, 5);
  endtask

  task automatic test_reset_mid();
    br_valid = 4'b0001; br_data[0 +: DW] = 8'hA1;
    @(posedge clk); #1;
    br_valid = 4'b0100; br_data[2*DW +: DW] = 8'hA2;
    @(posedge clk); #1;
    br_valid = '0;
    @(posedge clk); #1;
    n_checks++;
    if (br_ready !== 4'b1010 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid collecting: got rdy=%b v=%b expected rdy=1010 v=0", br_ready, out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (br_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid ready during rst: got %b expected 0000", br_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({out_valid, out_data, out_mask, out_mismatch, out_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got v=%b d=%h m=%b mis=%b to=%b expected all 0",
               out_valid, out_data, out_mask, out_mismatch, out_timeout);
    end
    #1;
    n_checks++;
    if (br_ready !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_mid ready after rst: got %b expected 1111", br_ready);
    end
    // A fresh round where branches 0 and 2 are absent exposes stale state.
    t_off[0] = -1; t_off[1] = 0; t_off[2] = -1; t_off[3] = 3;
    for (int i = 0; i < NB; i++) t_dat[i] = 8'h3C;
    run_round("reset_mid_fresh", 1'b0, 0);
  endtask

  task automatic test_random();
    logic [DW-1:0] base;
    bit any;
    for (int r = 0; r < 20; r++) begin
      base = DW'($urandom);
      any  = 1'b0;
      for (int i = 0; i < NB; i++) begin
        t_off[i] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 19));
        t_dat[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : base;
        if (t_off[i] >= 0) any = 1'b1;
      end
      if (!any) t_off[$urandom_range(0, NB - 1)] = 0;
      run_round($sformatf("random_%0d", r), 1'(($urandom & 1)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_all_at_once();
    test_staggered();
    test_mismatch();
    test_timeout();
    test_completion_wins();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
